datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath_pkg.sv | 24 ++
 rtl/datapath_if.sv | 28 ++
 rtl/datapath_alu.sv | 55 +++++
 rtl/datapath.sv | 68 ++++++
 tb/tb_datapath.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath: word width, register reset value,
// ALU op codes and the 64-bit ALU result payload.
package datapath_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 4;

    localparam logic [WORD_W-1:0] REG_RST = '0;

    localparam logic [OP_W-1:0] OP_AND = 4'h0;
    localparam logic [OP_W-1:0] OP_OR  = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_NOT = 4'h4;
    localparam logic [OP_W-1:0] OP_NEG = 4'h5;
    localparam logic [OP_W-1:0] OP_MUL = 4'hB;
    localparam logic [OP_W-1:0] OP_DIV = 4'hC;

    typedef struct packed {
        logic [WORD_W-1:0] hi;
        logic [WORD_W-1:0] lo;
    } alu_res_t;

endpackage

// File: rtl/datapath_if.sv
// Control strobes, memory data and observed bus of the datapath.
interface datapath_if;
    import datapath_pkg::*;

    logic [WORD_W-1:0] Mdatain;
    logic              Read;
    logic              MDRin, IRin, Yin, R1in, R4in, R5in, LOin, HIin;
    logic              PCout, MDRout, R4out, R5out, Zlowout, Zhighout;
    logic              AND;
    logic [WORD_W-1:0] BusMuxOut;

    modport master (
        output Mdatain, Read,
        output MDRin, IRin, Yin, R1in, R4in, R5in, LOin, HIin,
        output PCout, MDRout, R4out, R5out, Zlowout, Zhighout,
        output AND,
        input  BusMuxOut
    );

    modport slave (
        input  Mdatain, Read,
        input  MDRin, IRin, Yin, R1in, R4in, R5in, LOin, HIin,
        input  PCout, MDRout, R4out, R5out, Zlowout, Zhighout,
        input  AND,
        output BusMuxOut
    );

endinterface

// File: rtl/datapath_alu.sv
// Combinational ALU producing a 64-bit {hi,lo} result from A=Y and B=bus.
// The signed divider is only built when DATAPATH_DIV_EN is defined.
module alu
    import datapath_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output alu_res_t          res_c
);

    localparam int unsigned PROD_W = 2 * WORD_W;

    logic signed [PROD_W-1:0] prod_c;
    alu_res_t                 div_c;

    assign prod_c = PROD_W'($signed(a)) * PROD_W'($signed(b));

`ifdef DATAPATH_DIV_EN
    localparam logic [WORD_W-1:0] INT_MIN = {1'b1, {(WORD_W-1){1'b0}}};

    // Divide-by-zero and INT_MIN/-1 return fixed patterns instead of trapping
    always_comb begin : divider
        div_c = '0;
        if (b == '0) begin
            div_c.lo = '1;
            div_c.hi = a;
        end else if ((a == INT_MIN) && (b == '1)) begin
            div_c.lo = INT_MIN;
        end else begin
            div_c.lo = WORD_W'($signed(a) / $signed(b));
            div_c.hi = WORD_W'($signed(a) % $signed(b));
        end
    end
`else
    assign div_c = '0;
`endif

    // Unassigned op codes fall back to AND
    always_comb begin : op_sel
        res_c = '0;
        case (op)
            OP_AND:  res_c.lo = a & b;
            OP_OR:   res_c.lo = a | b;
            OP_ADD:  res_c.lo = a + b;
            OP_SUB:  res_c.lo = a - b;
            OP_NOT:  res_c.lo = ~b;
            OP_NEG:  res_c.lo = WORD_W'(0) - b;
            OP_MUL:  res_c    = alu_res_t'(prod_c);
            OP_DIV:  res_c    = div_c;
            default: res_c.lo = a & b;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// Single-bus datapath: register file, prioritized bus mux and Z capture of
// the ALU result. DATAPATH_DIV_EN enables the divider inside alu.
module datapath
    import datapath_pkg::*;
(
    input  logic      clock,
    input  logic      clear,
    datapath_if.slave dp
);

    logic [WORD_W-1:0] pc, mdr, ir, y, r1, r4, r5, lo, hi, z_lo, z_hi;
    logic [WORD_W-1:0] bus_c;
    alu_res_t          alu_res_c;
    logic              unused_ir;

    // Bus source priority: PC, MDR, R4, R5, Zhigh, Zlow; idle bus reads 0
    always_comb begin : bus_mux
        bus_c = '0;
        if (dp.PCout)         bus_c = pc;
        else if (dp.MDRout)   bus_c = mdr;
        else if (dp.R4out)    bus_c = r4;
        else if (dp.R5out)    bus_c = r5;
        else if (dp.Zhighout) bus_c = z_hi;
        else if (dp.Zlowout)  bus_c = z_lo;
    end

    assign dp.BusMuxOut = bus_c;

    alu u_alu (
        .a     (y),
        .b     (bus_c),
        .op    (ir[OP_W-1:0]),
        .res_c (alu_res_c)
    );

    assign unused_ir = ^ir[WORD_W-1:OP_W];

    // PC has no load path: it only ever takes its reset value
    always_ff @(posedge clock or negedge clear) begin : regs
        if (!clear) begin
            pc   <= REG_RST;
            mdr  <= REG_RST;
            ir   <= REG_RST;
            y    <= REG_RST;
            r1   <= REG_RST;
            r4   <= REG_RST;
            r5   <= REG_RST;
            lo   <= REG_RST;
            hi   <= REG_RST;
            z_lo <= REG_RST;
            z_hi <= REG_RST;
        end else begin
            if (dp.MDRin) mdr <= dp.Read ? dp.Mdatain : bus_c;
            if (dp.IRin)  ir  <= bus_c;
            if (dp.Yin)   y   <= bus_c;
            if (dp.R1in)  r1  <= bus_c;
            if (dp.R4in)  r4  <= bus_c;
            if (dp.R5in)  r5  <= bus_c;
            if (dp.LOin)  lo  <= bus_c;
            if (dp.HIin)  hi  <= bus_c;
            if (dp.AND) begin
                z_hi <= alu_res_c.hi;
                z_lo <= alu_res_c.lo;
            end
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: stimulus queues expected observations,
// a negedge monitor pops and compares them against the DUT.
module tb_datapath;
    import datapath_pkg::*;

    logic clock = 1'b0;
    logic clear = 1'b1;

    always #5 clock = ~clock;

    datapath_if dif ();

    datapath dut (
        .clock (clock),
        .clear (clear),
        .dp    (dif)
    );

    localparam int OBS_BUS = 0, OBS_MDR = 1, OBS_IR = 2, OBS_Y = 3, OBS_R1 = 4,
                   OBS_R4 = 5, OBS_R5 = 6, OBS_LO = 7, OBS_HI = 8, OBS_ZLO = 9,
                   OBS_ZHI = 10, OBS_PC = 11;
    localparam int SEL_IR = 0, SEL_Y = 1, SEL_R1 = 2, SEL_R4 = 3, SEL_R5 = 4;

`ifdef DATAPATH_DIV_EN
    localparam logic [31:0] D_LO  = 32'h4,        D_HI  = 32'h2;
    localparam logic [31:0] DZ_LO = 32'hFFFFFFFF, DZ_HI = 32'h7;
    localparam logic [31:0] OV_LO = 32'h80000000, OV_HI = 32'h0;
    localparam logic [31:0] NG_LO = 32'hFFFFFFFD, NG_HI = 32'hFFFFFFFF;
`else
    localparam logic [31:0] D_LO  = 32'h0, D_HI  = 32'h0;
    localparam logic [31:0] DZ_LO = 32'h0, DZ_HI = 32'h0;
    localparam logic [31:0] OV_LO = 32'h0, OV_HI = 32'h0;
    localparam logic [31:0] NG_LO = 32'h0, NG_HI = 32'h0;
`endif

    typedef struct {
        string       name;
        int          what;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] observe(int what);
        case (what)
            OBS_BUS: return dif.BusMuxOut;
            OBS_MDR: return dut.mdr;
            OBS_IR:  return dut.ir;
            OBS_Y:   return dut.y;
            OBS_R1:  return dut.r1;
            OBS_R4:  return dut.r4;
            OBS_R5:  return dut.r5;
            OBS_LO:  return dut.lo;
            OBS_HI:  return dut.hi;
            OBS_ZLO: return dut.z_lo;
            OBS_ZHI: return dut.z_hi;
            OBS_PC:  return dut.pc;
            default: return 'x;
        endcase
    endfunction

    task automatic expect_val(input string name, input int what, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.what = what;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs settle mid-cycle, so compare on the falling edge
    initial begin : monitor
        forever begin
            @(negedge clock);
            while (exp_q.size() != 0) begin
                exp_t        e;
                logic [31:0] act;
                e   = exp_q.pop_front();
                act = observe(e.what);
                checks++;
                if (act !== e.val) begin
                    failures++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.val);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        dif.Read = 0; dif.MDRin = 0; dif.IRin = 0; dif.Yin = 0; dif.R1in = 0;
        dif.R4in = 0; dif.R5in = 0; dif.LOin = 0; dif.HIin = 0;
        dif.PCout = 0; dif.MDRout = 0; dif.R4out = 0; dif.R5out = 0;
        dif.Zlowout = 0; dif.Zhighout = 0; dif.AND = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        dif.Mdatain = v; dif.Read = 1; dif.MDRin = 1;
        step();
    endtask

    task automatic load_via_mdr(input logic [31:0] v, input int which);
        load_mdr(v);
        dif.MDRout = 1;
        case (which)
            SEL_IR:  dif.IRin = 1;
            SEL_Y:   dif.Yin  = 1;
            SEL_R1:  dif.R1in = 1;
            SEL_R4:  dif.R4in = 1;
            default: dif.R5in = 1;
        endcase
        step();
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi);
        load_via_mdr(32'(op), SEL_IR);
        load_via_mdr(a, SEL_Y);
        load_mdr(b);
        dif.MDRout = 1; dif.AND = 1;
        step();
        dif.Zlowout = 1;
        expect_val({name, "_zlo"}, OBS_BUS, exp_lo);
        step();
        dif.Zhighout = 1;
        expect_val({name, "_zhi"}, OBS_BUS, exp_hi);
        step();
    endtask

    initial begin : stimulus
        idle();
        dif.Mdatain = 32'h0;
        #2 clear = 0;
        dif.MDRout = 1;
        expect_val("rst_bus", OBS_BUS, 32'h0);
        expect_val("rst_pc",  OBS_PC,  32'h0);
        expect_val("rst_mdr", OBS_MDR, 32'h0);
        expect_val("rst_ir",  OBS_IR,  32'h0);
        expect_val("rst_r4",  OBS_R4,  32'h0);
        expect_val("rst_zlo", OBS_ZLO, 32'h0);
        @(posedge clock);
        #1;
        clear = 1;
        idle();

        // Register load through MDR into R4
        load_mdr(32'h12);
        expect_val("mdr_load", OBS_MDR, 32'h12);
        dif.MDRout = 1; dif.R4in = 1;
        expect_val("mdr_bus", OBS_BUS, 32'h12);
        step();
        expect_val("r4_load", OBS_R4, 32'h12);

        // Division 0x12 / 0x4 through the full control sequence
        load_via_mdr(32'h4, SEL_R5);
        expect_val("r5_load", OBS_R5, 32'h4);
        load_via_mdr(32'hC, SEL_IR);
        expect_val("ir_load", OBS_IR, 32'hC);
        dif.R4out = 1; dif.Yin = 1;
        step();
        expect_val("y_load", OBS_Y, 32'h12);
        dif.R5out = 1; dif.AND = 1;
        step();
        dif.Zlowout = 1; dif.LOin = 1;
        expect_val("div_zlo_bus", OBS_BUS, D_LO);
        step();
        expect_val("div_lo", OBS_LO, D_LO);
        dif.Zhighout = 1; dif.HIin = 1;
        expect_val("div_zhi_bus", OBS_BUS, D_HI);
        step();
        expect_val("div_hi", OBS_HI, D_HI);

        run_op("div0",  OP_DIV, 32'h7,        32'h0,        DZ_LO, DZ_HI);
        run_op("divov", OP_DIV, 32'h80000000, 32'hFFFFFFFF, OV_LO, OV_HI);
        run_op("divng", OP_DIV, 32'hFFFFFFF9, 32'h2,        NG_LO, NG_HI);
        run_op("mul",   OP_MUL, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFA, 32'hFFFFFFFF);
        run_op("and",   OP_AND, 32'hF0, 32'h3C, 32'h30,       32'h0);
        run_op("or",    OP_OR,  32'hF0, 32'h3C, 32'hFC,       32'h0);
        run_op("add",   OP_ADD, 32'hF0, 32'h3C, 32'h12C,      32'h0);
        run_op("addw",  OP_ADD, 32'hFFFFFFFF, 32'h2, 32'h1,   32'h0);
        run_op("sub",   OP_SUB, 32'hF0, 32'h3C, 32'hB4,       32'h0);
        run_op("subw",  OP_SUB, 32'h1,  32'h2,  32'hFFFFFFFF, 32'h0);
        run_op("not",   OP_NOT, 32'hF0, 32'h3C, 32'hFFFFFFC3, 32'h0);
        run_op("neg",   OP_NEG, 32'hF0, 32'h3C, 32'hFFFFFFC4, 32'h0);
        run_op("op7",   4'h7,   32'hF0, 32'h3C, 32'h30,       32'h0);

        // Z holds while AND is low even though the ALU input changes
        for (int i = 0; i < 3; i++) begin
            dif.R4out = 1;
            step();
        end
        dif.Zlowout = 1;
        expect_val("z_hold", OBS_BUS, 32'h30);
        step();

        // Bus priority and idle bus
        load_mdr(32'hAA);
        dif.MDRout = 1; dif.R4out = 1;
        expect_val("prio_mdr_r4", OBS_BUS, 32'hAA);
        step();
        dif.PCout = 1; dif.MDRout = 1;
        expect_val("prio_pc_mdr", OBS_BUS, 32'h0);
        step();
        dif.R4out = 1; dif.R5out = 1;
        expect_val("prio_r4_r5", OBS_BUS, 32'h12);
        step();
        dif.Zhighout = 1; dif.Zlowout = 1;
        expect_val("prio_zhi_zlo", OBS_BUS, 32'h0);
        step();
        expect_val("bus_idle", OBS_BUS, 32'h0);
        step();

        // Simultaneous loads and self-loads
        dif.MDRout = 1; dif.R1in = 1; dif.R5in = 1; dif.Yin = 1;
        step();
        expect_val("multi_r1", OBS_R1, 32'hAA);
        expect_val("multi_r5", OBS_R5, 32'hAA);
        expect_val("multi_y",  OBS_Y,  32'hAA);
        dif.R4out = 1; dif.R4in = 1;
        step();
        expect_val("self_r4", OBS_R4, 32'h12);
        dif.MDRout = 1; dif.MDRin = 1; dif.Read = 0;
        step();
        expect_val("self_mdr", OBS_MDR, 32'hAA);

        // Asynchronous reset between edges with live Z, LO, HI
        run_op("add4", OP_ADD, 32'h2, 32'h2, 32'h4, 32'h0);
        dif.Zlowout = 1; dif.LOin = 1;
        step();
        dif.R4out = 1; dif.HIin = 1;
        step();
        expect_val("pre_lo", OBS_LO, 32'h4);
        expect_val("pre_hi", OBS_HI, 32'h12);
        step();
        #2 clear = 0;
        dif.Zlowout = 1; dif.R5out = 1; dif.AND = 1;
        expect_val("clr_bus", OBS_BUS, 32'h0);
        expect_val("clr_zlo", OBS_ZLO, 32'h0);
        expect_val("clr_zhi", OBS_ZHI, 32'h0);
        expect_val("clr_lo",  OBS_LO,  32'h0);
        expect_val("clr_hi",  OBS_HI,  32'h0);
        expect_val("clr_mdr", OBS_MDR, 32'h0);
        expect_val("clr_ir",  OBS_IR,  32'h0);
        @(negedge clock);
        #1;
        clear = 1;
        idle();
        step();
        expect_val("post_clr_zlo", OBS_ZLO, 32'h0);
        load_mdr(32'h77);
        expect_val("post_clr_mdr", OBS_MDR, 32'h77);

        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
